// File: rtl/ready_send_pkg.sv
// Shared types and widths for the ready_send level-ready CDC transmitter.
// The WAIT_LOW state is only reachable when READY_SEND_ACK_EN is defined.
package ready_send_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        GAP      = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned TX_COUNT_W = 16;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer with synchronous active-high reset.
// Used for the receiver acknowledge when READY_SEND_ACK_EN is defined.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ready_send.sv
// Source side of the level-ready CDC handshake: latches one word, holds ready high,
// then forces a low gap. Macro READY_SEND_ACK_EN switches to an ack-driven handshake.
module ready_send
    import ready_send_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned GAP_CYCLES  = 5
) (
    input  logic                  clk1,
    input  logic                  rst1,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] data,
    output logic [TX_COUNT_W-1:0] tx_count
`ifdef READY_SEND_ACK_EN
    ,
    input  logic                  ack
`endif
);

    if (HOLD_CYCLES < 3 || HOLD_CYCLES > 255) begin : g_hold_range
        $error("ready_send: HOLD_CYCLES must be in 3..255");
    end

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    ready_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [TX_COUNT_W-1:0]   tx_count_q;
    logic                    accept;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

`ifdef READY_SEND_ACK_EN
    logic ack_s;

    sync_2ff u_ack_sync (
        .clk_i (clk1),
        .rst_i (rst1),
        .d_i   (ack),
        .q_o   (ack_s)
    );

    always_ff @(posedge clk1) begin
        if (rst1) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            data_q     <= '0;
            tx_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= data_in;
                        ready_q <= 1'b1;
                        cnt_q   <= HOLD_LOAD;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // The counter is loaded but ignored: the receiver's ack ends the hold.
                    if (ack_s) begin
                        ready_q    <= 1'b0;
                        tx_count_q <= tx_count_q + TX_COUNT_W'(1);
                        state_q    <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!ack_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
`else
    if (GAP_CYCLES < 2 || GAP_CYCLES > 255) begin : g_gap_range
        $error("ready_send: GAP_CYCLES must be in 2..255");
    end

    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    always_ff @(posedge clk1) begin
        if (rst1) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            data_q     <= '0;
            tx_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= data_in;
                        ready_q <= 1'b1;
                        cnt_q   <= HOLD_LOAD;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        ready_q    <= 1'b0;
                        cnt_q      <= GAP_LOAD;
                        tx_count_q <= tx_count_q + TX_COUNT_W'(1);
                        state_q    <= GAP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
`endif

    assign ready    = ready_q;
    assign data     = data_q;
    assign tx_count = tx_count_q;

endmodule

// File: tb/tb_ready_send.sv
// Directed self-checking bench for ready_send in its default (timer-based) build.
module tb_ready_send;

    logic        clk1 = 1'b0;
    logic        rst1;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  data_in;
    logic        ready;
    logic [7:0]  data;
    logic [15:0] tx_count;

    int checks = 0;
    int errors = 0;

    ready_send #(
        .DATA_WIDTH  (8),
        .HOLD_CYCLES (10),
        .GAP_CYCLES  (5)
    ) dut (
        .clk1     (clk1),
        .rst1     (rst1),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .ready    (ready),
        .data     (data),
        .tx_count (tx_count)
    );

    always #5 clk1 = ~clk1;

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst1     = 1'b1;
        in_valid = 1'b1;
        data_in  = 8'hA5;

        // Reset with a pending word: nothing is accepted.
        repeat (5) tick();
        chk("rst_ready",    16'(ready),    16'h0);
        chk("rst_data",     16'(data),     16'h00);
        chk("rst_txcount",  tx_count,      16'h0);
        chk("rst_in_ready", 16'(in_ready), 16'h1);
        in_valid = 1'b0;
        rst1     = 1'b0;
        tick();
        chk("post_rst_ready", 16'(ready), 16'h0);

        // Reset in the middle of HOLD abandons the word.
        data_in  = 8'h5A;
        in_valid = 1'b1;
        tick();                         // accept edge t
        in_valid = 1'b0;
        chk("mid_accept_ready", 16'(ready), 16'h1);
        chk("mid_accept_data",  16'(data),  16'h5A);
        repeat (3) tick();              // cycle t+4
        rst1 = 1'b1;
        tick();                         // cycle t+5
        rst1 = 1'b0;
        chk("mid_rst_ready",    16'(ready),    16'h0);
        chk("mid_rst_data",     16'(data),     16'h00);
        chk("mid_rst_txcount",  tx_count,      16'h0);
        chk("mid_rst_in_ready", 16'(in_ready), 16'h1);
        repeat (12) tick();
        chk("mid_rst_no_incr",  tx_count,      16'h0);
        chk("mid_rst_idle_rdy", 16'(ready),    16'h0);

        // Single transfer; data_in changes after accept must not reach data.
        data_in  = 8'h3C;
        in_valid = 1'b1;
        chk("single_in_ready_pre", 16'(in_ready), 16'h1);
        tick();                         // accept edge t
        in_valid = 1'b0;
        data_in  = 8'hFF;
        for (int k = 1; k <= 15; k++) begin
            chk($sformatf("single_ready_t%0d", k), 16'(ready), (k <= 10) ? 16'h1 : 16'h0);
            chk($sformatf("single_data_t%0d", k),  16'(data),  16'h3C);
            chk($sformatf("single_inrdy_t%0d", k), 16'(in_ready), 16'h0);
            if (k == 10) chk("single_tx_before", tx_count, 16'h0);
            if (k == 11) chk("single_tx_after",  tx_count, 16'h1);
            tick();
        end
        chk("single_in_ready_t16", 16'(in_ready), 16'h1);
        chk("single_txcount",      tx_count,      16'h1);

        // Back-to-back words with in_valid held high: accepts every 16 cycles.
        in_valid = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            data_in = 8'(w);
            chk($sformatf("b2b_in_ready_w%0d", w), 16'(in_ready), 16'h1);
            tick();
            data_in = 8'(w + 16);
            for (int k = 1; k <= 15; k++) begin
                chk($sformatf("b2b_w%0d_ready_t%0d", w, k), 16'(ready), (k <= 10) ? 16'h1 : 16'h0);
                chk($sformatf("b2b_w%0d_data_t%0d", w, k),  16'(data),  16'(w));
                tick();
            end
        end
        in_valid = 1'b0;
        chk("b2b_txcount", tx_count, 16'h4);
        chk("b2b_idle",    16'(in_ready), 16'h1);
        tick();
        chk("b2b_no_accept", 16'(ready), 16'h0);

        // Counter wrap from 0xFFFF.
        force dut.tx_count_q = 16'hFFFF;
        #1;
        release dut.tx_count_q;
        tick();
        chk("wrap_preload", tx_count, 16'hFFFF);
        data_in  = 8'hC3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("wrap_ready_low", 16'(ready), 16'h0);
        chk("wrap_txcount",   tx_count,   16'h0000);
        repeat (5) tick();
        chk("wrap_in_ready",  16'(in_ready), 16'h1);
        chk("wrap_data",      16'(data),     16'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
